// File: rtl/mem_bridge.sv
// Request/acknowledge memory bridge for the multicycle controller: latches one access,
// waits for mem_ack with a bounded timeout, holds read data. Optional: MEM_BRIDGE_ALIGN_CHK_EN.
module mem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              IorD,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] aluout,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_done;
   logic              r_busy;
   logic              r_err;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [ADDR_W-1:0] w_addr_sel;
   logic [ADDR_W-1:0] w_addr_word;
   logic              w_misaligned;

   assign w_addr_sel  = IorD ? aluout : pc;
   assign w_addr_word = w_addr_sel & WORD_MASK;
`ifdef MEM_BRIDGE_ALIGN_CHK_EN
   assign w_misaligned = (w_addr_sel != w_addr_word);
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 8'd0;
         r_rdata     <= '0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cpu_req) begin
                  r_cnt       <= 8'd0;
                  r_busy      <= 1'b1;
                  r_mem_wdata <= wdata;
                  if (w_misaligned) begin
                     // Misaligned access never reaches memory; report it as a failed completion.
                     r_mem_addr <= w_addr_sel;
                     r_mem_we   <= 1'b0;
                     r_err      <= 1'b1;
                     r_rdata    <= '0;
                     r_done     <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_mem_addr <= w_addr_word;
                     r_mem_we   <= cpu_we;
                     r_mem_req  <= 1'b1;
                     r_err      <= 1'b0;
                     r_state    <= REQ;
                  end
               end
            end
            REQ: begin
               // Ack takes priority over a timeout landing on the same edge.
               if (mem_ack) begin
                  if (!r_mem_we) r_rdata <= mem_rdata;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_err     <= 1'b1;
                  r_rdata   <= '0;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rdata     = r_rdata;
   assign done      = r_done;
   assign busy      = r_busy;
   assign err       = r_err;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: directed accesses against a configurable-latency memory model.
module tb_mem_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          req_cycles;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, IorD;
   logic [31:0] pc, aluout, wdata;
   logic [31:0] rdata;
   logic        done, busy, err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          n_chk = 0;
   int          n_pass = 0;
   int          extra_done = 0;
   exp_t        exp_q[$];

   int          cfg_waits = 0;
   bit          cfg_respond = 1'b1;
   logic [31:0] cfg_rdata = 32'h0;
   bit          late_ack = 1'b0;

   mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .IorD(IorD),
      .pc(pc), .aluout(aluout), .wdata(wdata), .rdata(rdata), .done(done),
      .busy(busy), .err(err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
   endtask

   // Memory model: acks after cfg_waits request cycles, sampled by the DUT on the next edge.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (late_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 32'h5A5A_5A5A;
         end else if (rst && mem_req && cfg_respond) begin
            if (wcnt == cfg_waits) begin
               mem_ack = 1'b1;
               mem_rdata = cfg_rdata;
            end else begin
               mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor: tracks request cycles/stability and checks each done against the scoreboard.
   initial begin
      int          req_cnt, busy_cnt;
      bit          seen, stable;
      logic [31:0] f_addr, f_wdata;
      logic        f_we;
      exp_t        e;
      req_cnt = 0; busy_cnt = 0; seen = 0; stable = 1;
      f_addr = 0; f_wdata = 0; f_we = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            req_cnt = 0; busy_cnt = 0; seen = 0; stable = 1;
         end else begin
            if (mem_req) begin
               if (!seen) begin
                  f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata; seen = 1;
               end else if (mem_addr !== f_addr || mem_we !== f_we || mem_wdata !== f_wdata) begin
                  stable = 0;
               end
               req_cnt++;
            end
            if (busy && !done) busy_cnt++;
            if (done) begin
               if (exp_q.size() == 0) begin
                  extra_done++;
               end else begin
                  e = exp_q.pop_front();
                  chk("rdata", rdata, e.rdata);
                  chk("err", {31'b0, err}, {31'b0, e.err});
                  chk("req_cycles", req_cnt, e.req_cycles);
                  chk("latency", busy_cnt, e.req_cycles);
                  if (e.req_cycles > 0) begin
                     chk("mem_addr", f_addr, e.addr);
                     chk("mem_we", {31'b0, f_we}, {31'b0, e.we});
                     chk("req_stable", {31'b0, stable}, 32'd1);
                     if (e.we) chk("mem_wdata", f_wdata, e.wdata);
                  end
               end
               req_cnt = 0; busy_cnt = 0; seen = 0; stable = 1;
            end
         end
      end
   end

   task automatic run_vec(input logic iord, input logic we, input logic [31:0] pcv,
                          input logic [31:0] alu, input logic [31:0] wd, input int waits,
                          input bit respond, input logic [31:0] mdata, input bit poke,
                          input logic [31:0] e_addr, input logic [31:0] e_rdata,
                          input logic e_err, input int e_req);
      exp_t e;
      bit   ok;
      e.addr = e_addr; e.we = we; e.wdata = wd;
      e.rdata = e_rdata; e.err = e_err; e.req_cycles = e_req;
      @(negedge clk);
      cfg_waits = waits; cfg_respond = respond; cfg_rdata = mdata;
      IorD = iord; cpu_we = we; pc = pcv; aluout = alu; wdata = wd;
      exp_q.push_back(e);
      cpu_req = 1'b1;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      if (poke) begin
         @(negedge clk);
         cpu_req = 1'b1; aluout = 32'h44; pc = 32'h48; cpu_we = ~we;
         @(posedge clk);
         #1 cpu_req = 1'b0;
      end
      ok = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      chk("busy_release", {31'b0, ok}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b1; IorD = 1'b1;
      pc = 32'h1111_1111; aluout = 32'h2222_2222; wdata = 32'h3333_3333;
      #12;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // fetch, zero wait
      run_vec(1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b1, 32'h2008_0005, 1'b0,
              32'h0000_3000, 32'h2008_0005, 1'b0, 1);
      // load, 3 wait states, with an ignored cpu_req while busy
      run_vec(1'b1, 1'b0, 32'h0, 32'h0000_0010, 32'h0, 3, 1'b1, 32'hDEAD_BEEF, 1'b1,
              32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 4);
      // store, 1 wait; rdata must keep the previous load value
      run_vec(1'b1, 1'b1, 32'h0, 32'h0000_0014, 32'h1234_5678, 1, 1'b1, 32'hFFFF_0000, 1'b0,
              32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 2);
      // timeout
      run_vec(1'b1, 1'b0, 32'h0, 32'h0000_0020, 32'h0, 0, 1'b0, 32'h0, 1'b0,
              32'h0000_0020, 32'h0, 1'b1, 16);
      // recovery clears err
      run_vec(1'b0, 1'b0, 32'h0000_3004, 32'h0, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0,
              32'h0000_3004, 32'hCAFE_F00D, 1'b0, 3);
      // misaligned address
`ifdef MEM_BRIDGE_ALIGN_CHK_EN
      run_vec(1'b1, 1'b0, 32'h0, 32'h0000_0013, 32'h0, 0, 1'b1, 32'h0BAD_C0DE, 1'b0,
              32'h0000_0013, 32'h0, 1'b1, 0);
`else
      run_vec(1'b1, 1'b0, 32'h0, 32'h0000_0013, 32'h0, 0, 1'b1, 32'h0BAD_C0DE, 1'b0,
              32'h0000_0010, 32'h0BAD_C0DE, 1'b0, 1);
`endif

      // reset during the second wait cycle, then a late ack
      @(negedge clk);
      cfg_waits = 10; cfg_respond = 1'b1; cfg_rdata = 32'h7777_7777;
      IorD = 1'b1; cpu_we = 1'b0; aluout = 32'h0000_0040;
      cpu_req = 1'b1;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_done", {31'b0, done}, 32'h0);
      chk("mid_rst_err", {31'b0, err}, 32'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      late_ack = 1'b1;
      repeat (4) @(negedge clk);
      late_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_ack_busy", {31'b0, busy}, 32'h0);
      chk("late_ack_mem_req", {31'b0, mem_req}, 32'h0);
      chk("late_ack_rdata", rdata, 32'h0);

      repeat (2) @(negedge clk);
      chk("unexpected_done", extra_done, 32'd0);
      chk("pending_done", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-access bridge placed directly downstream of the multicycle controller and datapath.
- Turns one controller memory request (instruction fetch or data load/store, selected by IorD) into a request/acknowledge transaction on a variable-latency memory port.
- Captures read data into a hold register (MDR role) and reports completion so the controller FSM can stall its IF/MEM state until then.
- Includes a bounded wait with a timeout error.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum cycles mem_req stays high without mem_ack before abort; legal range 2..255

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request from controller, level-sampled in IDLE only
- cpu_we  in  1  1 = store (controller MemWrite), 0 = read
- IorD  in  1  0 = address from pc, 1 = address from aluout
- pc  in  ADDR_W  program counter
- aluout  in  ADDR_W  ALUOut register (data address)
- wdata  in  DATA_W  store data (rt register value)
- rdata  out  DATA_W  read-data hold register
- done  out  1  one-cycle completion pulse
- busy  out  1  transaction in flight
- err  out  1  sticky access error
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory acknowledge
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - State IDLE, wait counter 0.
  - Asserting reset mid-transaction drops mem_req immediately, without waiting for a clock edge. A late mem_ack after reset is ignored.
- All outputs are registered. The FSM has states IDLE, REQ and DONE.
- IDLE:
  - busy=0, mem_req=0.
  - When cpu_req=1 at a clock edge:
    - latch mem_addr = IorD ? aluout : pc
    - latch mem_we = cpu_we
    - latch mem_wdata = wdata
    - clear err and the counter
    - set busy=1 and mem_req=1
    - go to REQ
  - mem_ack seen in IDLE is ignored.
- REQ:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack is sampled high.
  - On mem_ack=1:
    - if mem_we=0, rdata <= mem_rdata; on a write, rdata is unchanged
    - mem_req <= 0, mem_we <= 0
    - go to DONE
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 with no ack:
    - err <= 1, rdata <= 0
    - mem_req <= 0, mem_we <= 0
    - go to DONE
  - If ack and timeout occur in the same cycle, ack wins and err stays 0.
- DONE:
  - done=1 for exactly this one cycle.
  - busy <= 0, return to IDLE.
  - cpu_req is not sampled in DONE, so back-to-back accesses are separated by one IDLE cycle.
- Latency:
  - Accepted at edge 0; mem_req high from edge 0 to the ack edge.
  - If mem_ack is first high at edge k (k≥1), done is high during the cycle after edge k.
  - With a zero-wait memory (ack in the first REQ cycle), done is high 2 cycles after acceptance.
- Hold rules:
  - rdata holds its value until the next completed read or timeout.
  - err stays set until the next accepted request.
  - cpu_req while busy=1 is ignored; it is not queued.
- Widths: no arithmetic on addresses; the counter is 8 bits wide.

Optional Feature:
- Macro name: MEM_BRIDGE_ALIGN_CHK_EN.
- Defined:
  - At acceptance, if the selected address[1:0] != 0, no memory request is issued (mem_req stays 0).
  - FSM goes IDLE -> DONE directly; err=1 with done, rdata <= 0.
- Undefined:
  - mem_addr[1:0] is forced to 2'b00 and the access proceeds normally.
  - err is set only by timeout.

Test Plan:
1. Fetch, zero-wait:
   - Stimulus: IorD=0, pc=0x0000_3000, cpu_req=1 one cycle; memory acks in the first REQ cycle with 0x2008_0005.
   - Required: mem_addr=0x3000, mem_we=0; done pulses 2 cycles after acceptance; rdata=0x2008_0005; err=0.
2. Load, 3 wait states:
   - Stimulus: IorD=1, aluout=0x0000_0010; ack after 3 REQ cycles with 0xDEAD_BEEF.
   - Required: mem_req high 4 cycles; done one cycle after ack; rdata=0xDEAD_BEEF.
3. Store:
   - Stimulus: cpu_we=1, aluout=0x14, wdata=0x1234_5678; ack after 1 wait.
   - Required: mem_we=1 and mem_wdata=0x1234_5678 stable until ack; rdata unchanged; done=1.
4. Timeout:
   - Stimulus: TIMEOUT=16, mem_ack held 0.
   - Required: mem_req drops after 16 cycles; done=1, err=1, rdata=0.
   - Then a new request to a responsive memory completes with err cleared to 0.
5. Reset mid-REQ:
   - Stimulus: drive rst=0 asynchronously during wait cycle 2, then release; send a late mem_ack.
   - Required: mem_req, busy, done and err go to 0 immediately; the late ack causes no done.
6. Alignment:
   - Stimulus: aluout=0x0000_0013.
   - Required with MEM_BRIDGE_ALIGN_CHK_EN: mem_req never asserts; done=1 and err=1 one cycle after acceptance.
   - Required without: mem_addr=0x10 and a normal completion.
